// File: rtl/bp_dma_sequencer.sv
// bp_dma_sequencer: strided memory-to-memory copy engine.
// Reads count elements from rd_base + k*rd_stride, stages them in a small
// in-order buffer and writes them to wr_base + k*wr_stride. Read credits
// bound the number of reads in flight plus buffered data to buf_els_p, so
// read responses are always accepted while running.
//
// Ports:
//   clk_i, reset_i            single clock, synchronous active-high reset
//   start_i, count_i          start pulse (honoured only in IDLE) and element count
//   rd/wr_base_addr_i         start addresses, rd/wr_stride_i address increments
//   rd_req_*                  read request channel (valid/ready)
//   rd_resp_*                 in-order read response channel (valid/ready)
//   wr_req_*                  write request channel (valid/ready)
//   wr_ack_v_i                one pulse per completed write
//   busy_o, done_o            transfer in progress / one-cycle completion pulse
//   abort_i                   only when BP_DMA_SEQUENCER_ABORT_EN is defined:
//                             stops a running transfer and drains issued writes
module bp_dma_sequencer #(
  parameter int unsigned addr_width_p   = 32,
  parameter int unsigned stride_width_p = 32,
  parameter int unsigned count_width_p  = 32,
  parameter int unsigned data_width_p   = 64,
  parameter int unsigned buf_els_p      = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
`ifdef BP_DMA_SEQUENCER_ABORT_EN
  input  logic                      abort_i,
`endif
  input  logic                      start_i,
  input  logic [count_width_p-1:0]  count_i,
  input  logic [addr_width_p-1:0]   rd_base_addr_i,
  input  logic [addr_width_p-1:0]   wr_base_addr_i,
  input  logic [stride_width_p-1:0] rd_stride_i,
  input  logic [stride_width_p-1:0] wr_stride_i,
  output logic [addr_width_p-1:0]   rd_req_addr_o,
  output logic                      rd_req_v_o,
  input  logic                      rd_req_ready_and_i,
  input  logic [data_width_p-1:0]   rd_resp_data_i,
  input  logic                      rd_resp_v_i,
  output logic                      rd_resp_ready_and_o,
  output logic [addr_width_p-1:0]   wr_req_addr_o,
  output logic [data_width_p-1:0]   wr_req_data_o,
  output logic                      wr_req_v_o,
  input  logic                      wr_req_ready_and_i,
  input  logic                      wr_ack_v_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned ptr_width_lp = $clog2(buf_els_p);
  localparam int unsigned occ_width_lp = ptr_width_lp + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e state_r, state_n;

  logic [count_width_p-1:0]  count_r;
  logic [stride_width_p-1:0] rd_stride_r, wr_stride_r;
  logic [addr_width_p-1:0]   rd_addr_r, wr_addr_r;
  logic [count_width_p-1:0]  reads_r, resps_r, writes_r, acks_r;
  logic [data_width_p-1:0]   mem_r [buf_els_p];
  logic [ptr_width_lp-1:0]   rd_ptr_r, wr_ptr_r;
  logic [occ_width_lp-1:0]   occ_r;
  logic                      aborted_r;

  logic [count_width_p-1:0]  outstanding;
  logic                      credit_ok;
  logic                      start_go, rd_fire, resp_fire, enq, wr_fire, ack_fire, flush;
  logic                      abort_w;

`ifdef BP_DMA_SEQUENCER_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // Next-state, handshake strobes and outputs, all decoded from registered state.
  always_comb begin
    state_n             = state_r;
    rd_req_v_o          = 1'b0;
    rd_resp_ready_and_o = 1'b0;
    busy_o              = 1'b0;
    done_o              = 1'b0;
    start_go            = 1'b0;
    flush               = 1'b0;

    rd_req_addr_o = rd_addr_r;
    wr_req_addr_o = wr_addr_r;
    wr_req_data_o = mem_r[rd_ptr_r];

    // Credits use registered occupancy, so a slot freed this cycle is only
    // visible to the read side on the following cycle.
    outstanding = reads_r - resps_r;
    credit_ok   = (outstanding + count_width_p'(occ_r)) < count_width_p'(buf_els_p);

    wr_req_v_o = (occ_r != '0);
    wr_fire    = wr_req_v_o && wr_req_ready_and_i;

    case (state_r)
      IDLE: begin
        if (start_i) begin
          start_go = 1'b1;
          state_n  = (count_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy_o              = 1'b1;
        rd_req_v_o          = (reads_r < count_r) && credit_ok;
        rd_resp_ready_and_o = 1'b1;
        if (abort_w) begin
          flush   = 1'b1;
          state_n = DRAIN;
        end else if (wr_fire && ((writes_r + count_width_p'(1)) == count_r)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        // After an abort, late read responses are consumed and dropped.
        rd_resp_ready_and_o = aborted_r;
        if (acks_r == writes_r) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    rd_fire   = rd_req_v_o && rd_req_ready_and_i;
    resp_fire = rd_resp_v_i && rd_resp_ready_and_o;
    enq       = resp_fire && (state_r == RUN);
    ack_fire  = wr_ack_v_i && busy_o;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  // Configuration, address generators, progress counters and data buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r     <= '0;
      rd_stride_r <= '0;
      wr_stride_r <= '0;
      rd_addr_r   <= '0;
      wr_addr_r   <= '0;
      reads_r     <= '0;
      resps_r     <= '0;
      writes_r    <= '0;
      acks_r      <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      occ_r       <= '0;
      aborted_r   <= 1'b0;
      for (int i = 0; i < int'(buf_els_p); i++) mem_r[i] <= '0;
    end else if (start_go) begin
      count_r     <= count_i;
      rd_stride_r <= rd_stride_i;
      wr_stride_r <= wr_stride_i;
      rd_addr_r   <= rd_base_addr_i;
      wr_addr_r   <= wr_base_addr_i;
      reads_r     <= '0;
      resps_r     <= '0;
      writes_r    <= '0;
      acks_r      <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      occ_r       <= '0;
      aborted_r   <= 1'b0;
    end else begin
      if (rd_fire) begin
        rd_addr_r <= rd_addr_r + addr_width_p'(rd_stride_r);
        reads_r   <= reads_r + count_width_p'(1);
      end
      if (resp_fire) resps_r <= resps_r + count_width_p'(1);
      if (enq) begin
        mem_r[wr_ptr_r] <= rd_resp_data_i;
        wr_ptr_r        <= wr_ptr_r + ptr_width_lp'(1);
      end
      if (wr_fire) begin
        wr_addr_r <= wr_addr_r + addr_width_p'(wr_stride_r);
        writes_r  <= writes_r + count_width_p'(1);
        rd_ptr_r  <= rd_ptr_r + ptr_width_lp'(1);
      end
      case ({enq, wr_fire})
        2'b10:   occ_r <= occ_r + occ_width_lp'(1);
        2'b01:   occ_r <= occ_r - occ_width_lp'(1);
        default: occ_r <= occ_r;
      endcase
      if (ack_fire) acks_r <= acks_r + count_width_p'(1);
      // Abort drops everything buffered; the write already handshaken this
      // cycle still counts as issued and its ack is awaited.
      if (flush) begin
        occ_r     <= '0;
        rd_ptr_r  <= '0;
        wr_ptr_r  <= '0;
        aborted_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_dma_sequencer.sv
// Randomized scoreboard bench for bp_dma_sequencer (default parameters).
// Each started transfer pushes its expected read addresses and write
// address/data pairs; a monitor pops and compares on every handshake.
module tb_bp_dma_sequencer;

  logic        clk_i, reset_i, start_i;
  logic [31:0] count_i, rd_base_addr_i, wr_base_addr_i, rd_stride_i, wr_stride_i;
  logic [31:0] rd_req_addr_o, wr_req_addr_o;
  logic        rd_req_v_o, rd_req_ready_and_i;
  logic [63:0] rd_resp_data_i, wr_req_data_o;
  logic        rd_resp_v_i, rd_resp_ready_and_o;
  logic        wr_req_v_o, wr_req_ready_and_i, wr_ack_v_i, busy_o, done_o;
`ifdef BP_DMA_SEQUENCER_ABORT_EN
  logic        abort_i;
`endif

  bp_dma_sequencer #(
    .addr_width_p(32), .stride_width_p(32), .count_width_p(32),
    .data_width_p(64), .buf_els_p(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
`ifdef BP_DMA_SEQUENCER_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .count_i(count_i),
    .rd_base_addr_i(rd_base_addr_i), .wr_base_addr_i(wr_base_addr_i),
    .rd_stride_i(rd_stride_i), .wr_stride_i(wr_stride_i),
    .rd_req_addr_o(rd_req_addr_o), .rd_req_v_o(rd_req_v_o),
    .rd_req_ready_and_i(rd_req_ready_and_i),
    .rd_resp_data_i(rd_resp_data_i), .rd_resp_v_i(rd_resp_v_i),
    .rd_resp_ready_and_o(rd_resp_ready_and_o),
    .wr_req_addr_o(wr_req_addr_o), .wr_req_data_o(wr_req_data_o),
    .wr_req_v_o(wr_req_v_o), .wr_req_ready_and_i(wr_req_ready_and_i),
    .wr_ack_v_i(wr_ack_v_i), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wa_q[$];
  logic [63:0] exp_wd_q[$];
  logic [31:0] pend_rd[$];

  int reads_seen = 0, writes_seen = 0, acks_seen = 0;
  int done_cnt = 0, busy_cnt = 0, wr_v_cnt = 0, ack_pending = 0;
  int unsigned rd_rdy_pct = 100, resp_pct = 100, wr_rdy_pct = 100, ack_pct = 100;
  bit wr_hold = 1'b0, ack_hold = 1'b0;

  // Memory contents as seen by the reader: a fixed function of the address.
  function automatic logic [63:0] rdata(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, a * 32'h9E37_79B1};
  endfunction

  function automatic bit roll(input int unsigned p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Environment driver: ready/valid inputs change on the falling edge.
  always @(negedge clk_i) begin
    if (reset_i) begin
      rd_req_ready_and_i = 1'b0;
      rd_resp_v_i        = 1'b0;
      rd_resp_data_i     = '0;
      wr_req_ready_and_i = 1'b0;
      wr_ack_v_i         = 1'b0;
    end else begin
      rd_req_ready_and_i = roll(rd_rdy_pct);
      if (pend_rd.size() > 0 && roll(resp_pct)) begin
        rd_resp_v_i    = 1'b1;
        rd_resp_data_i = rdata(pend_rd[0]);
      end else begin
        rd_resp_v_i    = 1'b0;
        rd_resp_data_i = {$urandom, $urandom};
      end
      wr_req_ready_and_i = !wr_hold && roll(wr_rdy_pct);
      wr_ack_v_i         = !ack_hold && (ack_pending > 0) && roll(ack_pct);
    end
  end

  // Monitor: every handshake that the next rising edge will take.
  always @(negedge clk_i) begin
    #1;
    if (reset_i) begin
      pend_rd.delete();
      ack_pending = 0;
    end else begin
      if (rd_req_v_o && rd_req_ready_and_i) begin
        reads_seen++;
        if (exp_rd_q.size() == 0) chk("unexpected_read", 64'(rd_req_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("rd_addr", 64'(rd_req_addr_o), 64'(exp_rd_q.pop_front()));
        pend_rd.push_back(rd_req_addr_o);
      end
      if (rd_resp_v_i && rd_resp_ready_and_o) void'(pend_rd.pop_front());
      if (wr_req_v_o && wr_req_ready_and_i) begin
        writes_seen++;
        ack_pending++;
        if (exp_wa_q.size() == 0) chk("unexpected_write", 64'(wr_req_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("wr_addr", 64'(wr_req_addr_o), 64'(exp_wa_q.pop_front()));
          chk("wr_data", wr_req_data_o, exp_wd_q.pop_front());
        end
      end
      if (wr_ack_v_i) begin
        ack_pending--;
        acks_seen++;
      end
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
      if (wr_req_v_o) wr_v_cnt++;
    end
  end

  task automatic start_xfer(input logic [31:0] cnt, input logic [31:0] rb, input logic [31:0] wb,
                            input logic [31:0] rs, input logic [31:0] ws);
    for (int unsigned k = 0; k < cnt; k++) begin
      exp_rd_q.push_back(rb + k * rs);
      exp_wa_q.push_back(wb + k * ws);
      exp_wd_q.push_back(rdata(rb + k * rs));
    end
    @(negedge clk_i);
    start_i = 1'b1; count_i = cnt;
    rd_base_addr_i = rb; wr_base_addr_i = wb; rd_stride_i = rs; wr_stride_i = ws;
    @(negedge clk_i);
    start_i = 1'b0;
    count_i = $urandom; rd_base_addr_i = $urandom; wr_base_addr_i = $urandom;
    rd_stride_i = $urandom; wr_stride_i = $urandom;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  d0;
    bit  got;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_i); #2;
      if (done_cnt != d0) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done_o within %0d cycles", name, budget);
    end
    repeat (3) @(negedge clk_i);
    chk({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_reads_left"}, 64'(exp_rd_q.size()), 64'd0);
    chk({name, "_writes_left"}, 64'(exp_wa_q.size()), 64'd0);
    chk({name, "_acks_pending"}, 64'(ack_pending), 64'd0);
  endtask

  initial begin
    int r0, w0, a0, b0, d0, wv0;
    reset_i = 1'b1; start_i = 1'b0; count_i = '0;
    rd_base_addr_i = '0; wr_base_addr_i = '0; rd_stride_i = '0; wr_stride_i = '0;
`ifdef BP_DMA_SEQUENCER_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    chk("rst_rd_v", 64'(rd_req_v_o), 64'd0);
    chk("rst_wr_v", 64'(wr_req_v_o), 64'd0);
    chk("rst_resp_rdy", 64'(rd_resp_ready_and_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_rd_addr", 64'(rd_req_addr_o), 64'd0);
    chk("rst_wr_addr", 64'(wr_req_addr_o), 64'd0);
    chk("rst_wr_data", wr_req_data_o, 64'd0);
    reset_i = 1'b0;

    // Base copy, everything ready, acks one cycle after each write.
    start_xfer(4, 32'h1000, 32'h2000, 8, 8);
    wait_done("base", 200);

    // A start pulse while running must not disturb the transfer.
    rd_rdy_pct = 60; resp_pct = 60; wr_rdy_pct = 60; ack_pct = 60;
    start_xfer(6, 32'h8000, 32'h9000, 16, 24);
    repeat (2) @(negedge clk_i);
    start_i = 1'b1; count_i = 3; rd_base_addr_i = 32'hDEAD_0000; wr_base_addr_i = 32'hBEEF_0000;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done("start_ignored", 400);
    rd_rdy_pct = 100; resp_pct = 100; wr_rdy_pct = 100; ack_pct = 100;

    // Zero count: done_o in the cycle after start is sampled, no activity.
    b0 = busy_cnt; r0 = reads_seen; w0 = writes_seen;
    @(negedge clk_i);
    start_i = 1'b1; count_i = 0;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("zero_done_high", 64'(done_o), 64'd1);
    @(negedge clk_i);
    chk("zero_done_low", 64'(done_o), 64'd0);
    repeat (4) @(negedge clk_i);
    chk("zero_busy_never", 64'(busy_cnt - b0), 64'd0);
    chk("zero_no_reads", 64'(reads_seen - r0), 64'd0);
    chk("zero_no_writes", 64'(writes_seen - w0), 64'd0);

    // Write backpressure: the credit limit caps reads at the buffer depth.
    wr_hold = 1'b1;
    r0 = reads_seen;
    start_xfer(8, 32'h0001_0000, 32'h0002_0000, 8, 8);
    repeat (20) @(negedge clk_i);
    chk("bp_reads_issued", 64'(reads_seen - r0), 64'd4);
    chk("bp_rd_v_low", 64'(rd_req_v_o), 64'd0);
    wr_hold = 1'b0;
    wait_done("backpressure", 400);

    // Address wrap at the top of the address space.
    start_xfer(2, 32'hFFFF_FFF8, 32'h3000, 8, 8);
    wait_done("wrap", 200);

    // Reset on the cycle of the third read abandons the transfer.
    r0 = reads_seen;
    start_xfer(8, 32'h4000, 32'h5000, 8, 8);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i); #2;
      if (reads_seen - r0 >= 3) break;
    end
    chk("mid_reset_reached_3rd_read", 64'(reads_seen - r0 >= 3), 64'd1);
    reset_i = 1'b1;
    d0 = done_cnt;
    @(negedge clk_i);
    chk("mid_reset_rd_v", 64'(rd_req_v_o), 64'd0);
    chk("mid_reset_wr_v", 64'(wr_req_v_o), 64'd0);
    chk("mid_reset_busy", 64'(busy_o), 64'd0);
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("mid_reset_no_done", 64'(done_cnt - d0), 64'd0);
    start_xfer(5, 32'h4400, 32'h5500, 8, 8);
    wait_done("after_reset", 200);

`ifdef BP_DMA_SEQUENCER_ABORT_EN
    // Abort after two writes: no more writes, done only after the second ack.
    w0 = writes_seen; a0 = acks_seen; d0 = done_cnt;
    start_xfer(8, 32'h6000, 32'h7000, 8, 8);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i); #2;
      if (writes_seen - w0 >= 2) break;
    end
    wr_hold = 1'b1; ack_hold = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    wv0 = wr_v_cnt;
    repeat (6) @(negedge clk_i);
    chk("abort_writes", 64'(writes_seen - w0), 64'd2);
    chk("abort_no_wr_v", 64'(wr_v_cnt - wv0), 64'd0);
    chk("abort_wait_ack", 64'(done_cnt - d0), 64'd0);
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    ack_hold = 1'b0; wr_hold = 1'b0;
    wait_done("abort", 200);
    chk("abort_acks", 64'(acks_seen - a0), 64'd2);
    chk("abort_no_wr_v_after", 64'(wr_v_cnt - wv0), 64'd0);
`endif

    // Randomized transfers with random handshake rates.
    for (int t = 0; t < 6; t++) begin
      logic [31:0] cnt, rs, ws;
      cnt = 32'($urandom_range(24, 1));
      rs  = (t % 2 == 1) ? $urandom : 32'($urandom_range(4, 0)) * 32'd8;
      ws  = (t % 2 == 1) ? $urandom : 32'($urandom_range(4, 0)) * 32'd8;
      rd_rdy_pct = $urandom_range(100, 25); resp_pct = $urandom_range(100, 25);
      wr_rdy_pct = $urandom_range(100, 25); ack_pct = $urandom_range(100, 25);
      start_xfer(cnt, $urandom, $urandom, rs, ws);
      wait_done("random", 3000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
